// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent circular FIFOs with threshold flags, peek bus and error reporting.
// Latency: a write is counted after its edge and readable one edge later; data_out is registered.
// Backpressure: none towards the writer; overflow/underflow are dropped and reported on error.
// Build option VC_FIFO_STICKY_ERR_EN: error holds until reset/init (default: one-cycle pulse).
module vc_fifo_bank #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             init,
  input  logic [NUM_VC-1:0]                wr_enable,
  input  logic [NUM_VC-1:0]                rd_enable,
  input  logic [NUM_VC*DATA_WIDTH-1:0]     data_in,
  input  logic [NUM_VC*ADDR_WIDTH-1:0]     umbral_af,
  input  logic [NUM_VC*ADDR_WIDTH-1:0]     umbral_ae,
  output logic [NUM_VC*DATA_WIDTH-1:0]     data_out,
  output logic [NUM_VC*DATA_WIDTH-1:0]     data_peek,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC-1:0]                almost_empty,
  output logic [NUM_VC-1:0]                error,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Occupancy value of a completely full channel (one bit wider than the pointers).
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Either reset source clears state at the edge and forces the flags while low.
  logic rst_act;
  assign rst_act = ~reset | ~init;

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   af_thr;
    logic [ADDR_WIDTH:0]   ae_thr;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_req, rd_req;
    logic                  full_raw, empty_raw;
    logic                  wr_ok, rd_ok, err_evt;

    assign wr_req = wr_enable[k];
    assign rd_req = rd_enable[k];
    assign din    = data_in[k*DATA_WIDTH +: DATA_WIDTH];

    // umbral_af==0 puts the threshold at DEPTH, which only a full channel meets, so the flag stays low.
    assign af_thr = DEPTH_CNT - {1'b0, umbral_af[k*ADDR_WIDTH +: ADDR_WIDTH]};
    assign ae_thr = {1'b0, umbral_ae[k*ADDR_WIDTH +: ADDR_WIDTH]};

    assign full_raw  = (cnt_q == DEPTH_CNT);
    assign empty_raw = (cnt_q == '0);

    // A write into a full channel is still accepted when a pop frees the slot in the same cycle.
    assign wr_ok   = wr_req & (~full_raw | rd_req);
    assign rd_ok   = rd_req & ~empty_raw;
    assign err_evt = (wr_req & full_raw & ~rd_req) | (rd_req & empty_raw);

    // Next-state for pointers, occupancy, popped data and error.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      dout_d   = '0;
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
`ifdef VC_FIFO_STICKY_ERR_EN
      err_d = err_q | err_evt;
`else
      err_d = err_evt;
`endif
    end

    // Channel state registers with synchronous clear from reset or init.
    always_ff @(posedge clk) begin
      if (rst_act) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        dout_q   <= '0;
        err_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        dout_q   <= dout_d;
        err_q    <= err_d;
      end
    end

    // Storage array; contents survive reset, only writes accepted outside reset land here.
    always_ff @(posedge clk) begin
      if (wr_ok && !rst_act) begin
        mem_q[wr_ptr_q] <= din;
      end
    end

    assign full[k]         = ~rst_act & full_raw;
    assign empty[k]        = rst_act | empty_raw;
    assign almost_full[k]  = ~rst_act & (cnt_q >= af_thr) & ~full_raw;
    assign almost_empty[k] = ~rst_act & (cnt_q <= ae_thr) & ~empty_raw;
    assign error[k]        = err_q;

    assign count[k*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)] = cnt_q;
    assign data_out[k*DATA_WIDTH +: DATA_WIDTH]      = dout_q;
    // Head-of-queue word; only meaningful while the channel is non-empty.
    assign data_peek[k*DATA_WIDTH +: DATA_WIDTH]     = mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Testbench for vc_fifo_bank: directed scenarios plus random traffic against a queue model.
module tb_vc_fifo_bank;
  localparam int DW    = 6;
  localparam int AW    = 4;
  localparam int NV    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, init;
  logic [NV-1:0]        wr_enable, rd_enable;
  logic [NV*DW-1:0]     data_in;
  logic [NV*AW-1:0]     umbral_af, umbral_ae;
  logic [NV*DW-1:0]     data_out, data_peek;
  logic [NV-1:0]        full, empty, almost_full, almost_empty, error;
  logic [NV*(AW+1)-1:0] count;

  vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) dut (
    .clk(clk), .reset(reset), .init(init),
    .wr_enable(wr_enable), .rd_enable(rd_enable), .data_in(data_in),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .data_out(data_out), .data_peek(data_peek),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .count(count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of stored words per channel, plus expected registered outputs.
  logic [DW-1:0] mq [NV][$];
  logic [DW-1:0] m_dout [NV];
  logic [NV-1:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Compare every output of every channel against the model.
  task automatic check_state(input string tag);
    for (int k = 0; k < NV; k++) begin
      int  sz;
      int  af_t;
      int  ae_t;
      bit  rst_now;
      bit  e_full, e_empty, e_af, e_ae;
      sz      = mq[k].size();
      af_t    = DEPTH - int'(umbral_af[k*AW +: AW]);
      ae_t    = int'(umbral_ae[k*AW +: AW]);
      rst_now = !reset || !init;
      e_full  = !rst_now && (sz == DEPTH);
      e_empty = rst_now || (sz == 0);
      e_af    = !rst_now && (sz >= af_t) && (sz != DEPTH);
      e_ae    = !rst_now && (sz <= ae_t) && (sz != 0);
      chk($sformatf("%s_count%0d", tag, k), 32'(count[k*(AW+1) +: AW+1]), 32'(sz));
      chk($sformatf("%s_full%0d", tag, k), 32'(full[k]), 32'(e_full));
      chk($sformatf("%s_empty%0d", tag, k), 32'(empty[k]), 32'(e_empty));
      chk($sformatf("%s_afull%0d", tag, k), 32'(almost_full[k]), 32'(e_af));
      chk($sformatf("%s_aempty%0d", tag, k), 32'(almost_empty[k]), 32'(e_ae));
      chk($sformatf("%s_error%0d", tag, k), 32'(error[k]), 32'(m_err[k]));
      chk($sformatf("%s_dout%0d", tag, k), 32'(data_out[k*DW +: DW]), 32'(m_dout[k]));
      if (sz != 0)
        chk($sformatf("%s_peek%0d", tag, k), 32'(data_peek[k*DW +: DW]), 32'(mq[k][0]));
    end
  endtask

  // One clock cycle: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic [NV-1:0] wr, input logic [NV-1:0] rd, input logic [NV*DW-1:0] din,
                     input string tag);
    wr_enable = wr;
    rd_enable = rd;
    data_in   = din;
    @(posedge clk);
    for (int k = 0; k < NV; k++) begin
      int sz;
      bit ev;
      sz = mq[k].size();
      ev = 1'b0;
      if (!reset || !init) begin
        mq[k].delete();
        m_dout[k] = '0;
        m_err[k]  = 1'b0;
      end else begin
        m_dout[k] = '0;
        if (rd[k]) begin
          if (sz > 0) m_dout[k] = mq[k].pop_front();
          else        ev = 1'b1;
        end
        if (wr[k]) begin
          if (sz < DEPTH || rd[k]) mq[k].push_back(din[k*DW +: DW]);
          else                     ev = 1'b1;
        end
`ifdef VC_FIFO_STICKY_ERR_EN
        m_err[k] = m_err[k] | ev;
`else
        m_err[k] = ev;
`endif
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cyc('0, '0, '0, tag);
  endtask

  function automatic logic [NV*DW-1:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return r[NV*DW-1:0];
  endfunction

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    reset     = 1'b0;
    init      = 1'b1;
    wr_enable = '0;
    rd_enable = '0;
    data_in   = '0;
    umbral_af = {4'd3, 4'd3};
    umbral_ae = {4'd2, 4'd2};
    for (int k = 0; k < NV; k++) begin
      m_dout[k] = '0;
      m_err[k]  = 1'b0;
    end
    @(negedge clk);

    // Reset held for two cycles with random enables.
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      cyc(r[1:0], r[3:2], rnd_data(), "rst");
    end
    reset = 1'b1;
    idle("rst_rel");
    chk("rst_empty", 32'(empty), 32'(2'b11));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_dout", 32'(data_out), 32'(0));
    chk("rst_error", 32'(error), 32'(0));

    // Fill VC0 with 1..16 while VC1 idles.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(2'b01, 2'b00, {6'd0, 6'(i)}, "fill");
      if (i == 12) chk("fill_af_at12", 32'(almost_full[0]), 32'(0));
      if (i == 13) chk("fill_af_at13", 32'(almost_full[0]), 32'(1));
      if (i == 15) chk("fill_full_at15", 32'(full[0]), 32'(0));
    end
    chk("fill_full_at16", 32'(full[0]), 32'(1));
    chk("fill_af_off_full", 32'(almost_full[0]), 32'(0));
    cyc(2'b01, 2'b00, {6'd0, 6'd17}, "ovf");
    chk("ovf_error", 32'(error[0]), 32'(1));
    chk("ovf_count", 32'(count[AW:0]), 32'(16));
    chk("ovf_vc1_empty", 32'(empty[1]), 32'(1));

    // Drain VC0 and look at order and almost-empty.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(2'b00, 2'b01, '0, "drain");
      chk("drain_order", 32'(data_out[DW-1:0]), 32'(i));
      if (i == 13) chk("drain_ae_cnt3", 32'(almost_empty[0]), 32'(0));
      if (i == 14) chk("drain_ae_cnt2", 32'(almost_empty[0]), 32'(1));
      if (i == 15) chk("drain_ae_cnt1", 32'(almost_empty[0]), 32'(1));
    end
    chk("drain_empty", 32'(empty[0]), 32'(1));
    cyc(2'b00, 2'b01, '0, "udf");
    chk("udf_dout", 32'(data_out[DW-1:0]), 32'(0));
    chk("udf_error", 32'(error[0]), 32'(1));

    // VC1 full, then simultaneous push/pop of 0x2A for 20 cycles.
    for (int i = 1; i <= DEPTH; i++)
      cyc(2'b10, 2'b00, {6'(i + 32), 6'd0}, "fill1");
    for (int j = 1; j <= 20; j++) begin
      cyc(2'b10, 2'b10, {6'h2A, 6'd0}, "rw_full");
      chk("rw_full_count", 32'(count[2*(AW+1)-1 -: AW+1]), 32'(16));
      chk("rw_full_err", 32'(error[1]), 32'(0));
      if (j == 1)  chk("rw_first_pop", 32'(data_out[2*DW-1 -: DW]), 32'(33));
      if (j == 17) chk("rw_wrap_pop", 32'(data_out[2*DW-1 -: DW]), 32'(6'h2A));
    end

    // Independent channels: alternate push on VC0 and pop on VC1.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) cyc(2'b01, 2'b00, rnd_data(), "indep");
      else            cyc(2'b00, 2'b10, rnd_data(), "indep");
    end

    // Random traffic with changing thresholds and occasional init.
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        r = $urandom;
        umbral_af = r[NV*AW-1:0];
        umbral_ae = r[2*NV*AW-1:NV*AW];
      end
      r    = $urandom;
      init = (r[7:0] > 8'd3);
      cyc(r[9:8], r[11:10] & {r[12], r[13]}, rnd_data(), "rand");
    end
    init = 1'b1;

    // Mid-operation reset at count 7, with an error event just before it.
    umbral_af = {4'd3, 4'd3};
    umbral_ae = {4'd2, 4'd2};
    reset = 1'b0;
    idle("pre_rst");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cyc(2'b01, 2'b00, rnd_data(), "mid_fill");
    cyc(2'b01, 2'b10, rnd_data(), "mid_udf");
    chk("mid_count7", 32'(count[AW:0]), 32'(7));
    chk("mid_err_set", 32'(error[1]), 32'(1));
    reset = 1'b0;
    idle("mid_rst");
    chk("mid_rst_count", 32'(count[AW:0]), 32'(0));
    chk("mid_rst_empty", 32'(empty[0]), 32'(1));
    chk("mid_rst_err", 32'(error), 32'(0));
    reset = 1'b1;
    idle("post_rst");
    cyc(2'b00, 2'b01, '0, "pulse_udf");
    chk("pulse_set", 32'(error[0]), 32'(1));
    idle("pulse_after");
`ifdef VC_FIFO_STICKY_ERR_EN
    chk("sticky_hold", 32'(error[0]), 32'(1));
`else
    chk("pulse_width1", 32'(error[0]), 32'(0));
`endif
    idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_fifo_bank.md
# vc_fifo_bank

Multi-channel virtual-channel FIFO bank: `NUM_VC` independent circular FIFOs sharing one clock, each with its own write/read enables, programmable almost-full/almost-empty thresholds, status flags and overflow/underflow error. It is the generalised replacement for the single-channel VC FIFOs in the PCIe transmit-layer datapath. It sits between the packet classifier (writer) and the VC arbiter (reader), and exposes a head-of-queue peek bus so the arbiter can inspect data before popping.

## Interface
- `DATA_WIDTH`, 6, word width.
- `ADDR_WIDTH`, 4, pointer width; depth `DEPTH = 2**ADDR_WIDTH`.
- `NUM_VC`, 2, number of channels (1–8).
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `init` input 1: synchronous soft-init, active-low, same effect as `reset`.
- `wr_enable` input `NUM_VC`: per-channel push.
- `rd_enable` input `NUM_VC`: per-channel pop.
- `data_in` input `NUM_VC*DATA_WIDTH`: per-channel write data; channel k is at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `umbral_af` input `NUM_VC*ADDR_WIDTH`: per-channel almost-full threshold.
- `umbral_ae` input `NUM_VC*ADDR_WIDTH`: per-channel almost-empty threshold.
- `data_out` output `NUM_VC*DATA_WIDTH`: registered popped data.
- `data_peek` output `NUM_VC*DATA_WIDTH`: combinational `mem[rd_ptr]` per channel.
- `full`, `empty`, `almost_full`, `almost_empty` output `NUM_VC` each: per-channel flags.
- `error` output `NUM_VC`: per-channel overflow/underflow indicator.
- `count` output `NUM_VC*(ADDR_WIDTH+1)`: per-channel occupancy.

## Operation
- **Per channel k**: storage `mem[DEPTH]`, `wr_ptr` and `rd_ptr` (`ADDR_WIDTH` bits, wrap modulo `DEPTH`), and `cnt` (`ADDR_WIDTH+1` bits, range 0..`DEPTH`).
- **Reset/init**: if `reset==0` or `init==0` at a clock edge:
  - Cleared: pointers, `cnt`, `data_out`, error state.
  - Memory contents are not cleared.
  - Flags are forced to `empty=1`, all others 0, combinationally while `reset` or `init` is low.
- **Flags** (combinational from `cnt`):
  - `full = (cnt==DEPTH)`
  - `empty = (cnt==0)`
  - `almost_full = (cnt >= DEPTH-umbral_af) && !full`
  - `almost_empty = (cnt <= umbral_ae) && !empty`
- **Valid write**: `wr_enable` && (!full || `rd_enable`).
- **Valid read**: `rd_enable` && !empty.
- **Write only**: store at `wr_ptr`, increment `wr_ptr`, `cnt+1`.
- **Read only**: `data_out <= mem[rd_ptr]`, increment `rd_ptr`, `cnt-1`.
- **Both valid**: both execute; `cnt` is unchanged. This holds when full: the slot is freed and refilled in the same cycle.
- **Write while empty with read requested**: the write executes and the read is an underflow. `data_out` = 0.
- **Overflow** (`wr_enable` && full && !`rd_enable`): write discarded; pointers and `cnt` untouched; error event.
- **Underflow** (`rd_enable` && empty): read discarded; `data_out` = 0; error event.
- **No valid read on channel k**: `data_out[k] <= 0`.
- Channels are fully independent: any combination of enables across channels in the same cycle is legal.
- `data_peek[k]` is meaningful only while `empty[k]==0`.

## Timing
- Write to visible: a word written at edge N is reflected in `count`/flags after edge N, and is readable at edge N+1.
- Read latency: `data_out` is valid one cycle after the edge that samples `rd_enable`.
- `data_peek` follows `rd_ptr` combinationally, so it updates right after the popping edge.
- Reset takes effect at the first edge with `reset==0`. A mid-operation reset discards all queued data.
- Thresholds are sampled combinationally and may change at any time. `umbral_af==0` disables `almost_full`.

## Configuration
- Macro: `VC_FIFO_STICKY_ERR_EN`.
- **Defined**: `error[k]` is set by the first overflow/underflow and held until reset/init.
- **Undefined**: `error[k]` is a registered one-cycle pulse in the cycle after each offending edge. It is 0 otherwise.

## Test plan
- **Reset**: hold `reset=0` for 2 cycles with random enables, then release.
  - Required: `empty=2'b11`, `full=0`, `count=0`, `data_out=0`, `error=0`.
- **Fill VC0 while VC1 idle**: write 16 words 1..16 on VC0 with `umbral_af=3`.
  - Required: `almost_full[0]` rises at `count==13`; `full[0]` at 16.
  - Required: a 17th write sets `error[0]` and `count` stays 16.
  - Required: VC1 stays `empty`.
- **Drain VC0**: read 16 times.
  - Required: `data_out` = 1..16, each one cycle after its `rd_enable`.
  - Required: `almost_empty[0]` asserted for `count` 1..`umbral_ae` (`umbral_ae=2`).
  - Required: an extra read gives `data_out=0` and sets `error[0]`.
- **Simultaneous read+write when full**: VC1 full, then `wr_enable=rd_enable=1` with data 0x2A for 20 cycles.
  - Required: `count` stays 16 and no error.
  - Required: the oldest word pops each cycle and 0x2A appears after pointer wrap.
- **Independent channels**: alternate push on VC0 and pop on VC1 every cycle for 40 cycles.
  - Required: per-channel counts match a reference model.
  - Required: `data_peek` equals the next `data_out`.
- **Mid-operation reset, both builds**: assert `reset=0` while `count=7`.
  - Required: next cycle `count=0`, `empty=1`.
  - Required, sticky build: `error` cleared after reset.
  - Required, pulse build: `error` pulse width is exactly 1 cycle.
